// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Falling-edge down-counter with one-shot and periodic (auto-reload) modes.
//   A load captures load_val into both the count and the reload register and
//   starts a run; each enabled edge decrements the count, and the edge that
//   takes the count off 1 raises a one-cycle terminal-count pulse. In periodic
//   mode that edge reloads the count from the reload register; otherwise the
//   count parks at 0 in DONE.
//
// Ports
//   clk         in   1      clock; all state changes on the falling edge
//   reset       in   1      asynchronous, active-high reset
//   load        in   1      load request (priority over en in every state)
//   load_val    in   WIDTH  start and reload value
//   en          in   1      count enable
//   auto_reload in   1      periodic mode select, sampled on the terminal edge
//   q           out  WIDTH  current count (registered)
//   tc          out  1      terminal-count pulse (registered, one cycle)
//   busy        out  1      high while in RUN
//   zero        out  1      high when q == 0
// -----------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rl_q,    rl_d;
  logic             tc_q,    tc_d;

  // Next-state and next-count computation; load always wins over counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rl_d    = rl_q;
    tc_d    = 1'b0;

    if (load) begin
      cnt_d = load_val;
      rl_d  = load_val;
      // A zero load has nothing to count, so it goes straight to DONE.
      if (load_val != CNT_ZERO) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
              // Terminal edge: auto_reload is only looked at here.
              tc_d = 1'b1;
              if (auto_reload) begin
                cnt_d = rl_q;
              end else begin
                cnt_d   = CNT_ZERO;
                state_d = DONE;
              end
            end else begin
              // Count of 0 cannot occur in RUN; hold rather than wrap.
              cnt_d = cnt_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle state.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          rl_d    = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count, reload and pulse registers, clocked on the falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      rl_q    <= CNT_ZERO;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rl_q    <= rl_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign zero = (cnt_q == CNT_ZERO);

endmodule
